// File: rtl/bp_update_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_update_queue_pkg
//  Description : Shared widths, packet types and helper functions for the
//                EX -> BP branch training queue.
//  Revision    : 1.0  initial release
// ============================================================================
package bp_update_queue_pkg;

    // Superscalar width and PC width used by every EX/BP packet.
    localparam int N      = 3;
    localparam int XLEN   = 32;
    // Width able to hold a lane count of 0..N.
    localparam int LANE_W = $clog2(N + 1);

    // One resolved control-flow outcome from an execute lane.
    typedef struct packed {
        logic            valid;
        logic            cond_branch_en;
        logic            branch_en;
        logic            taken;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] target_PC;
        logic [XLEN-1:0] pred_NPC;
    } BR_RESOLVE_PACKET;

    // Training packet consumed by the branch predictor.
    typedef struct packed {
        logic            cond_branch_en;
        logic            branch_en;
        logic            cond_branch_taken;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] target_PC;
    } EX_BP_PACKET;

    // Architecturally correct next PC of a resolved branch.
    // Unconditional branches always redirect; PC+4 wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] actual_npc(input BR_RESOLVE_PACKET p);
        logic redirect;
        redirect = p.cond_branch_en ? p.taken : 1'b1;
        return redirect ? p.target_PC : (p.PC + XLEN'(4));
    endfunction

    // Map a resolved lane onto the predictor training format.
    function automatic EX_BP_PACKET to_ex_bp(input BR_RESOLVE_PACKET p);
        EX_BP_PACKET q;
        q.cond_branch_en    = p.cond_branch_en;
        q.branch_en         = p.branch_en;
        q.cond_branch_taken = p.taken & p.cond_branch_en;
        q.PC                = p.PC;
        q.target_PC         = p.target_PC;
        return q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_update_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bp_update_fifo
//  Description : N-in / N-out circular buffer of EX_BP_PACKETs. Up to N
//                entries are written per cycle at tail; up to N entries are
//                read from head and registered onto the output slots.
//  Revision    : 1.0  initial release
// ============================================================================
module bp_update_fifo
    import bp_update_queue_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic [LANE_W-1:0]            wr_cnt,
    input  EX_BP_PACKET [N-1:0]          wr_data,
    input  logic                         rd_en,
    output EX_BP_PACKET [N-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    EX_BP_PACKET       mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  occ;
    logic [LANE_W-1:0] rd_cnt;

    assign count = occ;

    // Entries leaving this cycle: min(occupancy, N) when the reader is ready.
    // Only entries present at the start of the cycle are eligible, so a
    // write never bypasses straight to the output.
    always_comb begin
        rd_cnt = '0;
        if (rd_en) begin
            rd_cnt = (occ >= CNT_W'(N)) ? LANE_W'(N) : LANE_W'(occ);
        end
    end

    // Store accepted entries in lane order at tail, tail+1, ... (mod DEPTH).
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (LANE_W'(i) < wr_cnt) begin
                mem[tail + PTR_W'(i)] <= wr_data[i];
            end
        end
    end

    // Pointer/occupancy bookkeeping and registered read slots.
    always_ff @(posedge clock) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            occ     <= '0;
            rd_data <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                rd_data[i] <= (LANE_W'(i) < rd_cnt) ? mem[head + PTR_W'(i)] : '0;
            end
            head <= head + PTR_W'(rd_cnt);
            tail <= tail + PTR_W'(wr_cnt);
            occ  <= occ + CNT_W'(wr_cnt) - CNT_W'(rd_cnt);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_update_queue.sv
`default_nettype none
// ============================================================================
//  Module      : bp_update_queue
//  Description : Producer side of the EX -> BP training interface. Classifies
//                resolved lanes, finds the oldest mispredict, drops younger
//                wrong-path lanes, and buffers surviving branches so BP
//                backpressure never loses a correct-path update.
//  Revision    : 1.0  initial release
// ============================================================================
module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                          clock,
    input  logic                          reset,
    input  BR_RESOLVE_PACKET [N-1:0]      br_resolve_in,
    input  logic                          bp_stall_in,
    output EX_BP_PACKET [N-1:0]           ex_bp_packet_out,
    output logic                          stall_out,
    output logic                          mispredict_out,
    output logic [XLEN-1:0]               mispredict_pc_out,
    output logic [$clog2(DEPTH+1)-1:0]    count_out
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]     lane_npc [N];
    EX_BP_PACKET [N-1:0] enq_data;
    logic [LANE_W-1:0]   surv_cnt;
    logic [LANE_W-1:0]   enq_cnt;
    logic                mis_found;
    logic [XLEN-1:0]     mis_npc;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    free_slots;

    // Resolved next PC of every lane.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane_npc[i] = actual_npc(br_resolve_in[i]);
        end
    end

    // Walk lanes oldest-first, packing branches until (and including) the
    // first mispredict; anything younger is wrong-path and is discarded.
    always_comb begin
        enq_data  = '0;
        surv_cnt  = '0;
        mis_found = 1'b0;
        mis_npc   = '0;
        for (int i = 0; i < N; i++) begin
            if (br_resolve_in[i].valid && br_resolve_in[i].branch_en && !mis_found) begin
                enq_data[surv_cnt] = to_ex_bp(br_resolve_in[i]);
                surv_cnt           = surv_cnt + LANE_W'(1);
                if (lane_npc[i] != br_resolve_in[i].pred_NPC) begin
                    mis_found = 1'b1;
                    mis_npc   = lane_npc[i];
                end
            end
        end
    end

    // All-or-nothing admission against the start-of-cycle free space; a
    // same-cycle dequeue is deliberately not credited.
    assign free_slots = CNT_W'(DEPTH) - fifo_count;
    assign stall_out  = CNT_W'(surv_cnt) > free_slots;
    assign enq_cnt    = stall_out ? '0 : surv_cnt;
    assign count_out  = fifo_count;

    bp_update_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_cnt  (enq_cnt),
        .wr_data (enq_data),
        .rd_en   (!bp_stall_in),
        .rd_data (ex_bp_packet_out),
        .count   (fifo_count)
    );

    // Register the recovery request of an accepted batch; the PC is held
    // between mispredicts so recovery logic can sample it late.
    always_ff @(posedge clock) begin
        if (reset) begin
            mispredict_out    <= 1'b0;
            mispredict_pc_out <= '0;
        end else if (!stall_out && mis_found) begin
            mispredict_out    <= 1'b1;
            mispredict_pc_out <= mis_npc;
        end else begin
            mispredict_out    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_update_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_update_queue
//  Description : Scoreboard bench for bp_update_queue. A queue-based model
//                predicts each cycle's registered outputs; a negedge monitor
//                pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bp_update_queue;
    import bp_update_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     bp_stall_in;
    BR_RESOLVE_PACKET [N-1:0] br_resolve_in;
    EX_BP_PACKET [N-1:0]      ex_bp_packet_out;
    logic                     stall_out;
    logic                     mispredict_out;
    logic [XLEN-1:0]          mispredict_pc_out;
    logic [CW-1:0]            count_out;

    always #5 clock = ~clock;

    bp_update_queue #(.DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .br_resolve_in     (br_resolve_in),
        .bp_stall_in       (bp_stall_in),
        .ex_bp_packet_out  (ex_bp_packet_out),
        .stall_out         (stall_out),
        .mispredict_out    (mispredict_out),
        .mispredict_pc_out (mispredict_pc_out),
        .count_out         (count_out)
    );

    typedef struct {
        EX_BP_PACKET [N-1:0] slots;
        logic                mis;
        logic [XLEN-1:0]     mpc;
        int                  cnt;
    } exp_t;

    exp_t             exp_q[$];
    EX_BP_PACKET      model_q[$];
    logic [XLEN-1:0]  model_pc = '0;
    int               vectors = 0;
    int               fails   = 0;
    bit               collect = 0;
    logic [XLEN-1:0]  seen_pcs[$];
    exp_t             mon_e;

    // Reference next PC: a not-taken conditional falls through, everything else jumps.
    function automatic logic [XLEN-1:0] ref_npc(input BR_RESOLVE_PACKET p);
        if (p.cond_branch_en && !p.taken) return p.PC + 32'd4;
        return p.target_PC;
    endfunction

    function automatic EX_BP_PACKET ref_pkt(input BR_RESOLVE_PACKET p);
        EX_BP_PACKET q;
        q.cond_branch_en    = p.cond_branch_en;
        q.branch_en         = p.branch_en;
        q.cond_branch_taken = p.cond_branch_en && p.taken;
        q.PC                = p.PC;
        q.target_PC         = p.target_PC;
        return q;
    endfunction

    function automatic BR_RESOLVE_PACKET mk(input logic v, input logic c, input logic b,
                                            input logic t, input logic [XLEN-1:0] pc,
                                            input logic [XLEN-1:0] tg, input logic [XLEN-1:0] pr);
        BR_RESOLVE_PACKET p;
        p.valid = v; p.cond_branch_en = c; p.branch_en = b; p.taken = t;
        p.PC = pc; p.target_PC = tg; p.pred_NPC = pr;
        return p;
    endfunction

    function automatic BR_RESOLVE_PACKET rand_lane();
        BR_RESOLVE_PACKET p;
        p.valid          = ($urandom_range(0, 3) != 0);
        p.branch_en      = ($urandom_range(0, 3) != 0);
        p.cond_branch_en = $urandom_range(0, 1) == 1;
        p.taken          = $urandom_range(0, 1) == 1;
        p.PC             = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        p.target_PC      = $urandom & 32'hFFFF_FFFC;
        p.pred_NPC       = ($urandom_range(0, 9) < 7) ? ref_npc(p) : ($urandom & 32'hFFFF_FFFC);
        return p;
    endfunction

    // Drive one cycle, check stall_out, advance the model, queue the expected outputs.
    task automatic step(input logic rst, input logic stl,
                        input BR_RESOLVE_PACKET [N-1:0] lanes, output logic stalled);
        exp_t             e;
        EX_BP_PACKET      acc[$];
        bit               found;
        bit               exp_stall;
        logic [XLEN-1:0]  fnpc;
        reset         = rst;
        bp_stall_in   = stl;
        br_resolve_in = lanes;
        #1;
        found = 0;
        fnpc  = '0;
        for (int i = 0; i < N; i++) begin
            if (lanes[i].valid && lanes[i].branch_en && !found) begin
                acc.push_back(ref_pkt(lanes[i]));
                if (ref_npc(lanes[i]) != lanes[i].pred_NPC) begin
                    found = 1;
                    fnpc  = ref_npc(lanes[i]);
                end
            end
        end
        exp_stall = acc.size() > (DEPTH - model_q.size());
        vectors++;
        if (stall_out !== exp_stall) begin
            fails++;
            $display("FAIL stall_out: got %b want %b", stall_out, exp_stall);
        end
        if (rst) begin
            model_q.delete();
            model_pc = '0;
            e.slots  = '0;
            e.mis    = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!stl && model_q.size() > 0) e.slots[i] = model_q.pop_front();
                else e.slots[i] = '0;
            end
            if (!exp_stall) begin
                foreach (acc[j]) model_q.push_back(acc[j]);
            end
            e.mis = !exp_stall && found;
            if (e.mis) model_pc = fnpc;
        end
        e.mpc   = model_pc;
        e.cnt   = model_q.size();
        stalled = exp_stall;
        @(posedge clock);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: every cycle the DUT presents a registered output set, compare it.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (ex_bp_packet_out[i] !== mon_e.slots[i]) begin
                    fails++;
                    $display("FAIL slot%0d: got %h want %h", i, ex_bp_packet_out[i], mon_e.slots[i]);
                end
                if (collect && ex_bp_packet_out[i].branch_en) seen_pcs.push_back(ex_bp_packet_out[i].PC);
            end
            vectors++;
            if (mispredict_out !== mon_e.mis) begin
                fails++;
                $display("FAIL mispredict_out: got %b want %b", mispredict_out, mon_e.mis);
            end
            vectors++;
            if (mispredict_pc_out !== mon_e.mpc) begin
                fails++;
                $display("FAIL mispredict_pc_out: got %h want %h", mispredict_pc_out, mon_e.mpc);
            end
            vectors++;
            if (int'(count_out) !== mon_e.cnt) begin
                fails++;
                $display("FAIL count_out: got %0d want %0d", count_out, mon_e.cnt);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    BR_RESOLVE_PACKET [N-1:0] lanes;
    logic                     st;
    int                       issued;
    int                       guard;
    int                       n;

    initial begin
        reset         = 1'b1;
        bp_stall_in   = 1'b0;
        br_resolve_in = '0;
        @(posedge clock);
        #1;

        // 1: reset held two cycles while valid lanes are driven
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) lanes[i] = mk(1, 1, 1, 1, 32'h40 + 32'(4 * i), 32'h80, 32'h0);
            step(1, 0, lanes, st);
        end

        // 2: correctly predicted not-taken branch on lane 1
        lanes    = '0;
        lanes[1] = mk(1, 1, 1, 0, 32'h4, 32'h18, 32'h8);
        step(0, 0, lanes, st);
        for (int c = 0; c < 3; c++) step(0, 0, '0, st);

        // 3: lane 0 mispredicts, lanes 1 and 2 are wrong-path
        lanes[0] = mk(1, 1, 1, 1, 32'h10, 32'h40, 32'h14);
        lanes[1] = mk(1, 1, 1, 1, 32'h20, 32'h60, 32'h60);
        lanes[2] = mk(1, 0, 1, 0, 32'h30, 32'h90, 32'h90);
        step(0, 0, lanes, st);
        for (int c = 0; c < 3; c++) step(0, 0, '0, st);

        // 4: backpressure, full, stall, then release
        for (int b = 0; b < 4; b++) begin
            lanes = '0;
            for (int i = 0; i < ((b == 3) ? 2 : 3); i++)
                lanes[i] = mk(1, 1, 1, 0, 32'h200 + 32'(16 * b + 4 * i), 32'h300, 32'h204 + 32'(16 * b + 4 * i));
            step(0, 1, lanes, st);
        end
        for (int c = 0; c < 5; c++) step(0, 0, '0, st);

        // 5: 20 in-order branches across pointer wrap with random backpressure
        collect = 1;
        seen_pcs.delete();
        issued  = 0;
        guard   = 0;
        while (issued < 20 && guard < 400) begin
            n = int'($urandom_range(1, 3));
            if (n > 20 - issued) n = 20 - issued;
            lanes = '0;
            for (int j = 0; j < n; j++)
                lanes[j] = mk(1, 1, 1, 0, 32'h100 + 32'(4 * (issued + j)), 32'h800, 32'h104 + 32'(4 * (issued + j)));
            step(0, logic'($urandom_range(0, 1)), lanes, st);
            if (!st) issued += n;
            guard++;
        end
        vectors++;
        if (issued != 20) begin
            fails++;
            $display("FAIL wrap_issue: issued %0d want 20", issued);
        end
        for (int c = 0; c < 8; c++) step(0, 0, '0, st);
        @(negedge clock);
        #1;
        collect = 0;
        vectors++;
        if (seen_pcs.size() != 20) begin
            fails++;
            $display("FAIL wrap_count: got %0d want 20", seen_pcs.size());
        end
        for (int i = 0; i < seen_pcs.size() && i < 20; i++) begin
            vectors++;
            if (seen_pcs[i] !== 32'h100 + 32'(4 * i)) begin
                fails++;
                $display("FAIL wrap_order%0d: got %h want %h", i, seen_pcs[i], 32'h100 + 32'(4 * i));
            end
        end

        // 6: reset with five entries queued
        lanes = '0;
        for (int i = 0; i < 3; i++) lanes[i] = mk(1, 0, 1, 0, 32'h500 + 32'(4 * i), 32'h600, 32'h600);
        step(0, 1, lanes, st);
        lanes[2] = '0;
        step(0, 1, lanes, st);
        step(1, 0, '0, st);
        for (int c = 0; c < 3; c++) step(0, 0, '0, st);

        // random traffic
        for (int c = 0; c < 250; c++) begin
            for (int i = 0; i < N; i++) lanes[i] = rand_lane();
            step(0, logic'($urandom_range(0, 9) < 3), lanes, st);
        end
        for (int c = 0; c < 6; c++) step(0, 0, '0, st);

        @(negedge clock);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_update_queue.md
Name: bp_update_queue

Overview:
- Producer end of the EX→BP training interface: collects resolved control-flow outcomes from the N execute lanes and drives `EX_BP_PACKET [`N-1:0]` into BP.
- Detects mispredictions by comparing each lane's actual next PC against the NPC the front end predicted. Reports the oldest mispredict (registered) for recovery.
- Buffers resolved branches in a circular FIFO, so BP backpressure or bursty resolution never drops a correct-path update. Sits between the EX stage and BP.

Parameters:
- N, `N, superscalar width; lanes in and packet slots out.
- DEPTH, 8, FIFO entries; power of two, DEPTH >= N.
- XLEN, `XLEN, PC width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- br_resolve_in  in  `N x BR_RESOLVE_PACKET  per-lane fields: valid, cond_branch_en, branch_en, taken, PC, target_PC, pred_NPC
- bp_stall_in  in  1  BP cannot accept updates this cycle
- ex_bp_packet_out  out  `N x EX_BP_PACKET  training packets to BP; fields cond_branch_en, branch_en, cond_branch_taken, PC, target_PC
- stall_out  out  1  combinational; this cycle's input batch is rejected and EX must hold it
- mispredict_out  out  1  registered; oldest accepted lane mispredicted
- mispredict_pc_out  out  XLEN  registered; correct fetch PC for recovery
- count_out  out  $clog2(DEPTH+1)  current occupancy (debug/verif)

Behaviour:
- Reset (sync, active-high):
  - head, tail and count go to 0.
  - All ex_bp_packet_out fields go to 0.
  - mispredict_out = 0, mispredict_pc_out = 0.
  - Reset overrides every other input in the same cycle. Reset mid-operation discards all queued entries.
- Lane classification:
  - A lane is a branch when valid && branch_en.
  - actual_npc = (cond_branch_en ? taken : 1) ? target_PC : PC+4. Arithmetic is XLEN-wide and wraps modulo 2^XLEN.
  - A branch lane mispredicts when actual_npc != pred_NPC.
  - The oldest mispredicting lane is the lowest index. Lanes with a higher index are wrong-path and are dropped: not enqueued, no effect.
- Accept rule:
  - k = number of surviving branch lanes.
  - stall_out = (k > DEPTH - count), using the count at the start of the cycle. The rule is all-or-nothing.
  - On stall nothing is enqueued and no mispredict is registered.
  - On accept, surviving lanes are written in lane order at tail, tail+1, … (mod DEPTH).
- Dequeue rule:
  - When !bp_stall_in, d = min(count, N) entries are dequeued from head.
  - Entry head+i is registered into ex_bp_packet_out[i] for i < d. Slots i >= d get all-zero fields.
  - Latency: an entry enqueued in cycle t appears on the output no earlier than cycle t+1.
  - When bp_stall_in is high, d = 0 and every output slot is all-zero. Entries are retained, not replayed.
- Field mapping: cond_branch_taken = taken & cond_branch_en. All other fields are copied.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + k_accepted - d. The accept check ignores same-cycle dequeue (conservative).
- Pointers wrap modulo DEPTH. Full is count == DEPTH; empty is count == 0. Order is preserved across wrap.
- Mispredict outputs:
  - The cycle after an accept with a mispredicting lane: mispredict_out = 1 and mispredict_pc_out = that lane's actual_npc.
  - Otherwise mispredict_out = 0 and mispredict_pc_out holds its last value.
  - The mispredicting branch itself is enqueued so BP trains on it.

Decomposition:
- In sys_defs.svh: the BR_RESOLVE_PACKET typedef, plus the existing EX_BP_PACKET, `N and `XLEN.
- One natural sub-module, bp_update_fifo: an N-in/N-out circular buffer with head, tail and count. The top level holds the classification, mispredict and accept logic.

Test Plan:
1. Reset: assert reset for 2 cycles with valid lanes driven → all outputs 0, count_out = 0, stall_out = 0.
2. Correct prediction: lane1 {cond=1, br=1, taken=0, PC=0x4, target=0x18, pred_NPC=0x8} → next cycle out[0] = {1, 1, 0, 0x4, 0x18}, out[1..2] zero, mispredict_out = 0.
3. Mispredict and wrong-path drop:
   - Stimulus: lane0 {PC=0x10, taken=1, target=0x40, pred_NPC=0x14}; lanes 1 and 2 are valid branches.
   - Response next cycle: mispredict_out = 1, mispredict_pc_out = 0x40, only lane0 on out[0], count_out returns to 0.
4. Backpressure and full:
   - Stimulus: bp_stall_in = 1; present 3 branches per cycle.
   - Response: count_out goes 3 → 6. The third batch raises stall_out with count staying at 6, and all outputs are zero. A batch of 2 then fills to 8.
   - Release the stall → out carries the 3 oldest in enqueue order.
5. Wrap-around: push 20 branches with PCs 0x100 + 4i, random bp_stall_in → every PC emerges exactly once, in order, with no duplicates.
6. Reset mid-operation: count_out = 5, assert reset → next cycle count_out = 0. After release, outputs stay zero with no inputs.
